expr_generator: RTL and testbench



---
 rtl/expr_generator.sv | 126 ++++++++++++
 tb/tb_expr_generator.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expr_generator.sv
// Random arithmetic puzzle source: LFSR draws filtered to answerable expressions, one strobe per interval.
// Optional macro GEN_DIV_EN enables the '/' operator; default build draws only + - *.
module expr_generator #(
   parameter logic [15:0] SEED        = 16'hACE1,
   parameter int unsigned BASE_PERIOD = 64,
   parameter int unsigned STEP        = 2,
   parameter int unsigned MIN_PERIOD  = 16,
   parameter int unsigned MAX_TRIES   = 8
) (
   input  logic        delay_clk,
   input  logic        rst,
   input  logic        run,
   input  logic [6:0]  score,
   output logic [11:0] tmp_exp,
   output logic [1:0]  line,
   output logic        update
);

   typedef enum logic [1:0] {IDLE, COUNT, GEN} state_t;

   localparam logic [15:0] SPAN = 16'(BASE_PERIOD - MIN_PERIOD);

   state_t      state, state_nx;
   logic [15:0] lfsr, lfsr_nx;
   logic [15:0] cnt, cnt_nx;
   logic [7:0]  tries, tries_nx;
   logic [11:0] exp_nx;
   logic [1:0]  line_nx;
   logic        upd_nx;

   logic [15:0] product, period, load;
   logic [3:0]  a, b, op;
   logic [1:0]  ln;
   logic        valid;

   assign lfsr_nx = {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);

   // Period is only sampled into cnt on COUNT entry, so later score changes do not disturb it
   assign product = 16'(score) * 16'(STEP);
   assign period  = (product >= SPAN) ? 16'(MIN_PERIOD) : 16'(BASE_PERIOD) - product;
   assign load    = period - 16'd1;

   assign a  = lfsr[3:0];
   assign b  = lfsr[7:4];
   assign ln = lfsr[11:10];

`ifdef GEN_DIV_EN
   assign op    = 4'hA + {2'b00, lfsr[9:8]};
   assign valid = (a <= 4'd9) && (b <= 4'd9) && (ln != 2'd3) &&
                  ((op != 4'hB) || (a >= b)) &&
                  ((op != 4'hD) || ((b != 4'd0) && ((a % b) == 4'd0)));
`else
   assign op    = (lfsr[9:8] == 2'd3) ? 4'hA : 4'hA + {2'b00, lfsr[9:8]};
   assign valid = (a <= 4'd9) && (b <= 4'd9) && (ln != 2'd3) &&
                  ((op != 4'hB) || (a >= b));
`endif

   always_ff @(posedge delay_clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         lfsr    <= SEED;
         cnt     <= '0;
         tries   <= '0;
         tmp_exp <= '0;
         line    <= '0;
         update  <= 1'b0;
      end else begin
         state   <= state_nx;
         lfsr    <= lfsr_nx;
         cnt     <= cnt_nx;
         tries   <= tries_nx;
         tmp_exp <= exp_nx;
         line    <= line_nx;
         update  <= upd_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tries_nx = tries;
      exp_nx   = tmp_exp;
      line_nx  = line;
      upd_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (run) begin
               state_nx = COUNT;
               cnt_nx   = load;
               tries_nx = '0;
            end
         end
         COUNT: begin
            if (!run) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               tries_nx = '0;
            end else if (cnt == '0) begin
               state_nx = GEN;
               tries_nx = '0;
            end else begin
               cnt_nx = cnt - 16'd1;
            end
         end
         GEN: begin
            if (!run) begin
               state_nx = IDLE;
               cnt_nx   = '0;
               tries_nx = '0;
            end else if (valid || ((32'(tries) + 32'd1) == MAX_TRIES)) begin
               // Out of draws: emit 1+1 on lane 0 so the interval never stretches further
               exp_nx   = valid ? {a, op, b} : 12'h1A1;
               line_nx  = valid ? ln : 2'd0;
               upd_nx   = 1'b1;
               state_nx = COUNT;
               cnt_nx   = load;
               tries_nx = '0;
            end else begin
               tries_nx = tries + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_expr_generator.sv
// Self-checking bench for expr_generator: lookahead strobe model plus directed interval, run-drop and reset scenarios.
module tb_expr_generator;

   localparam logic [15:0] SEED  = 16'hACE1;
   localparam int          BASE  = 64;
   localparam int          STEP  = 2;
   localparam int          MINP  = 16;
   localparam int          TRIES = 8;

   logic        delay_clk = 1'b0;
   logic        rst, run, run2;
   logic [6:0]  score;
   logic [11:0] tmp_exp, tmp_exp2;
   logic [1:0]  line, line2;
   logic        update, update2;

   int checks = 0;
   int errors = 0;
   bit started = 1'b0;

   always #5 delay_clk = ~delay_clk;

   expr_generator #(
      .SEED(SEED), .BASE_PERIOD(BASE), .STEP(STEP), .MIN_PERIOD(MINP), .MAX_TRIES(TRIES)
   ) dut (
      .delay_clk(delay_clk), .rst(rst), .run(run), .score(score),
      .tmp_exp(tmp_exp), .line(line), .update(update)
   );

   // First draw from this seed is 16'h03C0 (b=12), so a single try must fall back
   expr_generator #(
      .SEED(16'h0F00), .BASE_PERIOD(1), .STEP(2), .MIN_PERIOD(1), .MAX_TRIES(1)
   ) dut2 (
      .delay_clk(delay_clk), .rst(rst), .run(run2), .score(score),
      .tmp_exp(tmp_exp2), .line(line2), .update(update2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic chk_range(input string name, input int act, input int lo, input int hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   function automatic int period_of(input int s);
      int prod = s * STEP;
      return (prod >= BASE - MINP) ? MINP : BASE - prod;
   endfunction

   function automatic bit legal(input logic [11:0] te, input logic [1:0] ln);
      int a  = int'(te[11:8]);
      int op = int'(te[7:4]);
      int b  = int'(te[3:0]);
      bit ok = (te != 12'h000) && (a <= 9) && (b <= 9) && (ln <= 2) && (op >= 10);
`ifdef GEN_DIV_EN
      ok = ok && (op <= 13);
`else
      ok = ok && (op <= 12);
`endif
      if (op == 11) ok = ok && (a >= b);
      if (op == 13) ok = ok && (b != 0) && (a % b == 0);
      return ok;
   endfunction

   // Decode one LFSR value as a puzzle and judge whether it is answerable
   task automatic draw(input logic [15:0] l, output bit ok, output logic [11:0] te, output logic [1:0] ln);
      int a   = int'(l[3:0]);
      int b   = int'(l[7:4]);
      int sel = int'(l[9:8]);
`ifndef GEN_DIV_EN
      sel = sel % 3;
`endif
      ln = l[11:10];
      te = {l[3:0], 4'(10 + sel), l[7:4]};
      ok = (a <= 9) && (b <= 9) && (ln != 2'd3);
      if (sel == 1) ok = ok && (a >= b);
      if (sel == 3) ok = ok && (b != 0) && (a % b == 0);
   endtask

   // From the LFSR value in the entry cycle, find how many GEN cycles follow P and what is emitted
   task automatic predict(input logic [15:0] l_entry, input int p, output int gen_cycles,
                          output logic [11:0] te, output logic [1:0] ln);
      logic [15:0] l = l_entry;
      bit ok, found = 1'b0;
      logic [11:0] t;
      logic [1:0]  n;
      repeat (p) l = lstep(l);
      te = 12'h1A1;
      ln = 2'd0;
      gen_cycles = TRIES;
      for (int k = 0; k < TRIES; k++) begin
         if (!found) begin
            draw(l, ok, t, n);
            if (ok) begin
               found = 1'b1;
               te = t;
               ln = n;
               gen_cycles = k + 1;
            end
            l = lstep(l);
         end
      end
   endtask

   int          m_cyc, m_entry, m_p, m_strobe;
   logic [15:0] m_l;
   bit          m_active;
   logic [11:0] m_pay_te, exp_te;
   logic [1:0]  m_pay_ln, exp_ln;
   logic        exp_upd;

   task automatic start_interval(input int e, input logic [15:0] l_e);
      int g;
      m_active = 1'b1;
      m_entry  = e;
      m_p      = period_of(int'(score));
      predict(l_e, m_p, g, m_pay_te, m_pay_ln);
      m_strobe = e + m_p + g;
   endtask

   initial begin : model
      logic [15:0] nl;
      forever begin
         @(posedge delay_clk or negedge rst);
         if (!rst) begin
            m_cyc = 0; m_l = SEED; m_active = 1'b0;
            exp_upd = 1'b0; exp_te = '0; exp_ln = '0;
         end else begin
            nl = lstep(m_l);
            exp_upd = 1'b0;
            if (!m_active) begin
               if (run) start_interval(m_cyc + 1, nl);
            end else if (!run) begin
               m_active = 1'b0;
            end else if (m_cyc + 1 == m_strobe) begin
               exp_upd = 1'b1;
               exp_te  = m_pay_te;
               exp_ln  = m_pay_ln;
               start_interval(m_cyc + 1, nl);
            end
            m_l = nl;
            m_cyc++;
         end
      end
   end

   initial begin : compare
      forever begin
         @(negedge delay_clk);
         if (started) begin
            if (!rst) begin
               chk("reset_update", update, 1'b0);
               chk("reset_exp", tmp_exp, 12'h000);
               chk("reset_line", line, 2'd0);
            end else begin
               chk("update", update, exp_upd);
               chk("tmp_exp", tmp_exp, exp_te);
               chk("line", line, exp_ln);
               if (update) chk("strobe_legal", legal(tmp_exp, line), 1'b1);
               if (update2) chk("strobe2_legal", legal(tmp_exp2, line2), 1'b1);
            end
         end
      end
   end

   task automatic wait_strobe(output int n);
      n = 0;
      do begin
         @(negedge delay_clk);
         n++;
      end while (update !== 1'b1 && n < 200);
      if (update !== 1'b1) chk("strobe_timeout", 0, 1);
   endtask

   task automatic gap_phase(input int sc, input int lo, input int hi, input int count);
      int g;
      #1 score = 7'(sc);
      wait_strobe(g);
      repeat (count) begin
         wait_strobe(g);
         chk_range("gap", g, lo, hi);
      end
   endtask

   initial begin : stim
      int g, n;
      logic [11:0] held_te;
      logic [1:0]  held_ln;
      rst = 1'b0; run = 1'b0; run2 = 1'b1; score = '0;
      repeat (2) @(negedge delay_clk);
      started = 1'b1;
      @(negedge delay_clk);
      #1 rst = 1'b1; run = 1'b1;

      n = 0;
      do begin
         @(negedge delay_clk);
         n++;
      end while (update2 !== 1'b1 && n < 20);
      chk("fallback_seen", update2, 1'b1);
      chk("fallback_cycle", n, 3);
      chk("fallback_exp", tmp_exp2, 12'h1A1);
      chk("fallback_line", line2, 2'd0);

      gap_phase(0, 65, 72, 4);

      // Drop run when cnt reaches 5 (entry cycle + 58 with P=64)
      repeat (58) @(negedge delay_clk);
      #1 run = 1'b0;
      held_te = tmp_exp;
      held_ln = line;
      n = 0;
      repeat (30) begin
         @(negedge delay_clk);
         if (update) n++;
      end
      chk("drop_no_update", n, 0);
      chk("drop_hold_exp", tmp_exp, held_te);
      chk("drop_hold_line", line, held_ln);
      #1 run = 1'b1;
      wait_strobe(g);
      chk_range("restart_gap", g, 65, 72);

      gap_phase(10, 45, 52, 3);
      gap_phase(40, 17, 24, 3);

      // Score change mid-COUNT must not alter the interval already counting
      repeat (3) @(negedge delay_clk);
      #1 score = 7'd0;
      wait_strobe(g);
      chk_range("midcount_gap", g + 3, 17, 24);
      wait_strobe(g);
      chk_range("after_midcount_gap", g, 65, 72);

      gap_phase(127, 17, 24, 1500);

      // Land in the first GEN cycle (P=16 after the strobe) and reset there
      repeat (16) @(negedge delay_clk);
      #1 rst = 1'b0;
      #1;
      chk("rst_gen_exp", tmp_exp, 12'h000);
      chk("rst_gen_update", update, 1'b0);
      chk("rst_gen_line", line, 2'd0);
      repeat (2) @(negedge delay_clk);
      #1 rst = 1'b1;
      wait_strobe(g);
      wait_strobe(g);
      chk_range("post_reset_gap", g, 17, 24);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
